// File: rtl/vga_ca_scroller_if.sv
// Beam position, run-time controls and pixel/generation outputs of the CA scroller.
// The slave side is the renderer; the master side is whoever generates the beam.
interface vga_ca_scroller_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        display_on;
    logic [7:0]  rule;
    logic        wrap;
    logic        seed_mode;
    logic        freeze;
    logic        reseed;
    logic [5:0]  color;
    logic [5:0]  rgb;
    logic [15:0] gen_top;

    modport master (
        output pix_x, pix_y, display_on, rule, wrap, seed_mode, freeze, reseed, color,
        input  rgb, gen_top
    );
    modport slave (
        input  pix_x, pix_y, display_on, rule, wrap, seed_mode, freeze, reseed, color,
        output rgb, gen_top
    );
endinterface

// File: rtl/vga_ca_scroller.sv
// Elementary CA renderer: one generation per cell row, scrolling one generation per frame.
// Latency 1 clk beam->rgb; no backpressure, follows the free-running beam.
module vga_ca_scroller #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          LOG_CELL  = 2,
    parameter int          GRID_W    = 160,
    parameter int          PAD_LEFT  = (H_ACTIVE - GRID_W * (1 << LOG_CELL)) / 2,
    parameter int          ROWS      = V_ACTIVE >> LOG_CELL,
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_ca_scroller_if.slave   bus
);
    localparam int         CW      = $clog2(GRID_W);
    localparam logic [9:0] PAD_X   = 10'(PAD_LEFT);
    localparam logic [9:0] GRID_WX = 10'(GRID_W);
    localparam logic [9:0] ROWS_X  = 10'(ROWS);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_X = 10'(V_ACTIVE);

    // Out-of-range neighbours are folded into the shifted copies: zero, or the far edge when wrapping.
    function automatic logic [GRID_W-1:0] ca_step(input logic [GRID_W-1:0] r,
                                                   input logic [7:0]        rl,
                                                   input logic              wr);
        logic [GRID_W-1:0] lvec;
        logic [GRID_W-1:0] rvec;
        ca_step = '0;
        lvec    = {r[GRID_W-2:0], wr & r[GRID_W-1]};
        rvec    = {wr & r[0], r[GRID_W-1:1]};
        for (int i = 0; i < GRID_W; i++) begin
            ca_step[i] = rl[{lvec[i], r[i], rvec[i]}];
        end
    endfunction

    logic [GRID_W-1:0] cur_q, cur_d;
    logic [GRID_W-1:0] top_q, top_d;
    logic [GRID_W-1:0] top_next_q, top_next_d;
    logic [15:0]       gen_q, gen_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              pending_q, pending_d;
    logic [7:0]        rule_s_q, rule_s_d;
    logic              wrap_s_q, wrap_s_d;
    logic [5:0]        color_s_q, color_s_d;
    logic [5:0]        rgb_q, rgb_d;

    logic [GRID_W-1:0] lfsr_row, single_row, seed_row, fs_top, row_disp, stepped;
    logic [15:0]       lfsr_end, fs_gen;
    logic [9:0]        cell_x, cell_y;
    logic [5:0]        col;
    logic              fs, in_grid, adv;

    // Cell i takes bit 0 after the LFSR's (i+1)-th shift, so a seeded row consumes GRID_W shifts.
    always_comb begin
        logic [15:0] walk;
        walk     = lfsr_q;
        lfsr_row = '0;
        for (int i = 0; i < GRID_W; i++) begin
            walk        = {walk[0] ^ walk[2] ^ walk[3] ^ walk[5], walk[15:1]};
            lfsr_row[i] = walk[0];
        end
        lfsr_end = walk;
    end

    always_comb begin
        fs                     = (bus.pix_x == '0) && (bus.pix_y == '0);
        single_row             = '0;
        single_row[GRID_W/2]   = 1'b1;
        seed_row               = bus.seed_mode ? lfsr_row : single_row;

        fs_top = top_q;
        fs_gen = gen_q;
        if (pending_q) begin
            fs_top = seed_row;
            fs_gen = '0;
        end else if (!bus.freeze) begin
            fs_top = top_next_q;
            fs_gen = gen_q + 16'd1;
        end

        // The frame-start pixel must already use the new frame's top row and colour.
        cell_x   = (bus.pix_x - PAD_X) >> LOG_CELL;
        cell_y   = bus.pix_y >> LOG_CELL;
        in_grid  = bus.display_on && (bus.pix_x >= PAD_X) && (cell_x < GRID_WX) && (cell_y < ROWS_X);
        row_disp = fs ? fs_top : cur_q;
        col      = fs ? bus.color : color_s_q;
        rgb_d    = (in_grid && row_disp[cell_x[CW-1:0]]) ? col : '0;

        adv     = !fs && (bus.pix_x == H_LAST) && (&bus.pix_y[LOG_CELL-1:0]) && (bus.pix_y < V_ACT_X);
        stepped = ca_step(cur_q, rule_s_q, wrap_s_q);

        cur_d      = cur_q;
        top_d      = top_q;
        top_next_d = top_next_q;
        gen_d      = gen_q;
        lfsr_d     = lfsr_q;
        pending_d  = pending_q | bus.reseed;
        rule_s_d   = rule_s_q;
        wrap_s_d   = wrap_s_q;
        color_s_d  = color_s_q;

        if (fs) begin
            rule_s_d  = bus.rule;
            wrap_s_d  = bus.wrap;
            color_s_d = bus.color;
            cur_d     = fs_top;
            top_d     = fs_top;
            gen_d     = fs_gen;
            pending_d = bus.reseed;
            if (pending_q && bus.seed_mode) begin
                lfsr_d = lfsr_end;
            end
        end else if (adv) begin
            cur_d = stepped;
            if (cell_y == '0) begin
                top_next_d = stepped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q      <= '0;
            top_q      <= '0;
            top_next_q <= '0;
            gen_q      <= '0;
            lfsr_q     <= LFSR_INIT;
            pending_q  <= 1'b1;
            rule_s_q   <= '0;
            wrap_s_q   <= 1'b0;
            color_s_q  <= '0;
            rgb_q      <= '0;
        end else begin
            cur_q      <= cur_d;
            top_q      <= top_d;
            top_next_q <= top_next_d;
            gen_q      <= gen_d;
            lfsr_q     <= lfsr_d;
            pending_q  <= pending_d;
            rule_s_q   <= rule_s_d;
            wrap_s_q   <= wrap_s_d;
            color_s_q  <= color_s_d;
            rgb_q      <= rgb_d;
        end
    end

    assign bus.rgb     = rgb_q;
    assign bus.gen_top = gen_q;
endmodule

// File: tb/tb_vga_ca_scroller.sv
// Bench for vga_ca_scroller on a shrunken 64x48 raster, checked pixel-by-pixel against a frame model.
module tb_vga_ca_scroller;
    localparam int H_ACT = 64;
    localparam int V_ACT = 48;
    localparam int LOGC  = 2;
    localparam int CELL  = 1 << LOGC;
    localparam int GW    = 12;
    localparam int PAD   = (H_ACT - GW * CELL) / 2;
    localparam int ROWS  = V_ACT / CELL;
    localparam int H_TOT = 72;
    localparam int V_TOT = 50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_ca_scroller_if bus();

    vga_ca_scroller #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .LOG_CELL (LOGC),
        .GRID_W   (GW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp    = 0;
    int n_fail   = 0;
    int frame_no = 0;

    logic [5:0]    exp_img [V_TOT][H_TOT];
    logic [5:0]    act_img [V_TOT][H_TOT];
    logic [GW-1:0] rows_m  [ROWS];
    logic [GW-1:0] top_m, row1_m;
    logic [15:0]   lfsr_m;
    logic [15:0]   gen_m;
    bit            pending_m;

    function automatic logic [GW-1:0] next_gen(input logic [GW-1:0] r, input logic [7:0] rl, input bit w);
        logic [GW-1:0] n;
        int            nb [3];
        int            j;
        n = '0;
        for (int i = 0; i < GW; i++) begin
            for (int d = -1; d <= 1; d++) begin
                j = i + d;
                if (j >= 0 && j < GW) nb[d+1] = int'(r[j]);
                else if (w)           nb[d+1] = int'(r[(j + GW) % GW]);
                else                  nb[d+1] = 0;
            end
            n[i] = rl[4 * nb[0] + 2 * nb[1] + nb[2]];
        end
        return n;
    endfunction

    task automatic model_reset();
        pending_m = 1'b1;
        gen_m     = '0;
        lfsr_m    = 16'hACE1;
    endtask

    // Frame start: resolve the top row, then draw the whole expected frame from it.
    task automatic model_fs();
        logic [7:0]  r_s;
        bit          w_s;
        logic [5:0]  c_s;
        logic [15:0] fb;
        r_s = bus.rule;
        w_s = bus.wrap;
        c_s = bus.color;
        if (pending_m) begin
            top_m = '0;
            if (bus.seed_mode) begin
                for (int i = 0; i < GW; i++) begin
                    fb       = (lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 16'd1;
                    lfsr_m   = (lfsr_m >> 1) | (fb << 15);
                    top_m[i] = lfsr_m[0];
                end
            end else begin
                top_m[GW/2] = 1'b1;
            end
            gen_m = '0;
        end else if (!bus.freeze) begin
            top_m = row1_m;
            gen_m = gen_m + 16'd1;
        end
        pending_m = 1'b0;
        rows_m[0] = top_m;
        for (int r = 1; r < ROWS; r++) rows_m[r] = next_gen(rows_m[r-1], r_s, w_s);
        row1_m = rows_m[1];
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                exp_img[y][x] = '0;
                if (y < V_ACT && x >= PAD && x < PAD + GW * CELL && rows_m[y / CELL][(x - PAD) / CELL])
                    exp_img[y][x] = c_s;
            end
        end
    endtask

    // act: 1 = change rule, 2 = reseed pulse, 3 = one-clk reset; applied at pixel (mx,my).
    task automatic run_frame(input int mx, input int my, input int act, input logic [7:0] new_rule);
        int px, py, bad, fx, fy;
        model_fs();
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                @(negedge clk);
                if (!(x == 0 && y == 0)) begin
                    px = (x == 0) ? H_TOT - 1 : x - 1;
                    py = (x == 0) ? y - 1 : y;
                    act_img[py][px] = bus.rgb;
                end
                bus.pix_x      = 10'(x);
                bus.pix_y      = 10'(y);
                bus.display_on = (x < H_ACT) && (y < V_ACT);
                bus.reseed     = 1'b0;
                rst_n          = 1'b1;
                if (x == mx && y == my) begin
                    case (act)
                        1: bus.rule = new_rule;
                        2: begin bus.reseed = 1'b1; pending_m = 1'b1; end
                        3: begin
                            rst_n = 1'b0;
                            model_reset();
                            for (int yy = 0; yy < V_TOT; yy++)
                                for (int xx = 0; xx < H_TOT; xx++)
                                    if (yy * H_TOT + xx >= my * H_TOT + mx) exp_img[yy][xx] = '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
        @(negedge clk);
        act_img[V_TOT-1][H_TOT-1] = bus.rgb;
        bus.reseed = 1'b0;
        rst_n      = 1'b1;
        bad = 0; fx = 0; fy = 0;
        for (int y = 0; y < V_TOT; y++)
            for (int x = 0; x < H_TOT; x++)
                if (act_img[y][x] !== exp_img[y][x]) begin
                    if (bad == 0) begin fx = x; fy = y; end
                    bad++;
                end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frame%0d image: %0d pixels differ, first (%0d,%0d) got %h want %h",
                     frame_no, bad, fx, fy, act_img[fy][fx], exp_img[fy][fx]);
        end
        n_cmp++;
        if (bus.gen_top !== gen_m) begin
            n_fail++;
            $display("FAIL frame%0d gen_top: got %0d want %0d", frame_no, bus.gen_top, gen_m);
        end
        frame_no++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pix_x = 10'(H_TOT - 1); bus.pix_y = 10'(V_TOT - 1); bus.display_on = 1'b0;
        bus.rule = 8'd90; bus.wrap = 1'b0; bus.seed_mode = 1'b0; bus.freeze = 1'b0;
        bus.reseed = 1'b0; bus.color = 6'h3F;
        repeat (3) @(negedge clk);
        model_reset();
        n_cmp++;
        if (bus.rgb !== 6'd0) begin n_fail++; $display("FAIL reset rgb: got %h want 00", bus.rgb); end
        n_cmp++;
        if (bus.gen_top !== 16'd0) begin n_fail++; $display("FAIL reset gen_top: got %0d want 0", bus.gen_top); end
        rst_n = 1'b1;
    endtask

    task automatic test_rule90();
        run_frame(0, 20, 2, 8'd0);
        n_cmp++;
        if (act_img[0][32] !== 6'h3F || act_img[3][35] !== 6'h3F) begin
            n_fail++; $display("FAIL rule90 centre: got %h/%h want 3f", act_img[0][32], act_img[3][35]);
        end
        n_cmp++;
        if (act_img[0][31] !== 6'h00 || act_img[0][36] !== 6'h00) begin
            n_fail++; $display("FAIL rule90 centre edge: got %h/%h want 00", act_img[0][31], act_img[0][36]);
        end
        n_cmp++;
        if (act_img[4][28] !== 6'h3F || act_img[4][36] !== 6'h3F || act_img[4][32] !== 6'h00) begin
            n_fail++; $display("FAIL rule90 row1: got %h %h %h want 3f 00 3f", act_img[4][28], act_img[4][32], act_img[4][36]);
        end
    endtask

    task automatic test_rule170();
        int lit;
        bus.rule = 8'd170; bus.wrap = 1'b0; bus.color = 6'($urandom_range(1, 63));
        run_frame(0, 20, 2, 8'd0);
        n_cmp++;
        if (act_img[24][PAD] !== bus.color) begin
            n_fail++; $display("FAIL rule170 row6 cell0: got %h want %h", act_img[24][PAD], bus.color);
        end
        lit = 0;
        for (int x = 0; x < H_TOT; x++) if (act_img[28][x] !== 6'd0) lit++;
        n_cmp++;
        if (lit != 0) begin n_fail++; $display("FAIL rule170 row7 empty: got %0d lit want 0", lit); end
        bus.wrap = 1'b1;
        run_frame(0, 20, 2, 8'd0);
        n_cmp++;
        if (act_img[28][PAD + 11 * CELL] !== bus.color || act_img[44][PAD + 7 * CELL] !== bus.color) begin
            n_fail++; $display("FAIL rule170 wrap: got %h/%h want %h",
                               act_img[28][PAD + 11 * CELL], act_img[44][PAD + 7 * CELL], bus.color);
        end
    endtask

    task automatic test_scroll();
        bus.rule = 8'd30; bus.wrap = 1'($urandom_range(0, 1)); bus.color = 6'($urandom_range(1, 63));
        repeat (3) run_frame(0, 0, 0, 8'd0);
        bus.freeze = 1'b1;
        repeat (2) run_frame(0, 0, 0, 8'd0);
        n_cmp++;
        if (bus.gen_top !== 16'd2) begin n_fail++; $display("FAIL freeze gen_top: got %0d want 2", bus.gen_top); end
        bus.freeze = 1'b0;
    endtask

    task automatic test_rule_change();
        bus.rule = 8'd30;
        run_frame(0, 20, 1, 8'd110);
        bus.color = 6'($urandom_range(1, 63));
        run_frame(0, 20, 2, 8'd0);
    endtask

    task automatic test_lfsr_reseed();
        bus.seed_mode = 1'b1; bus.rule = 8'($urandom); bus.wrap = 1'($urandom_range(0, 1));
        run_frame(10, 30, 2, 8'd0);
        bus.freeze = 1'b1;
        run_frame(0, 0, 0, 8'd0);
        n_cmp++;
        if (bus.gen_top !== 16'd0) begin n_fail++; $display("FAIL reseed over freeze gen_top: got %0d want 0", bus.gen_top); end
        bus.freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.seed_mode = 1'b0; bus.rule = 8'd255; bus.color = 6'($urandom_range(1, 63));
        run_frame(20, 24, 3, 8'd0);
        n_cmp++;
        if (act_img[24][20] !== 6'd0) begin n_fail++; $display("FAIL mid reset rgb: got %h want 00", act_img[24][20]); end
        run_frame(0, 20, 2, 8'd0);
    endtask

    task automatic test_edges();
        bus.rule = 8'd255; bus.wrap = 1'b0; bus.color = 6'($urandom_range(1, 63));
        run_frame(0, 0, 0, 8'd0);
        n_cmp++;
        if (act_img[4][PAD - 1] !== 6'd0 || act_img[4][PAD] !== bus.color) begin
            n_fail++; $display("FAIL left edge: got %h %h want 00 %h", act_img[4][PAD - 1], act_img[4][PAD], bus.color);
        end
        n_cmp++;
        if (act_img[4][PAD + GW * CELL - 1] !== bus.color || act_img[4][PAD + GW * CELL] !== 6'd0) begin
            n_fail++; $display("FAIL right edge: got %h %h want %h 00",
                               act_img[4][PAD + GW * CELL - 1], act_img[4][PAD + GW * CELL], bus.color);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rule90();
        test_rule170();
        test_scroll();
        test_rule_change();
        test_lfsr_reseed();
        test_reset_mid();
        test_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
